// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad front end.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } keypad_state_t;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 3;
  localparam int NUM_KEYS = 10;

  // Column-major key numbering: k = 3*col + row.
  function automatic logic [3:0] key_index(input logic [1:0] col, input logic [1:0] row);
    return 4'(3 * int'(col) + int'(row));
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for asynchronous, active-low pad inputs; resets to all-ones (idle).
// Latency: 2 clk cycles from i_d to o_q.
// Backpressure: none; samples every cycle.
// Ports: clk, nrst (sync active-high), i_d (async input), o_q (synchronized output).
module row_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column scan, row sync, press/release debounce, one-hot pb strobe.
// Latency: pb strobes DEBOUNCE_CYCLES+1 edges after the scan sample edge; pb is registered.
// Backpressure: none; pb is a single-cycle strobe that is not held or queued.
// Ports: clk, nrst (sync active-high), row_n[2:0] (async, active-low),
//        col_n[3:0] (one bit low), pb[9:0] (strobe), key_valid, key_idx[3:0].
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 100,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [2:0] row_n,
  output logic [3:0] col_n,
  output logic [9:0] pb,
  output logic       key_valid,
  output logic [3:0] key_idx
);

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  // Debounce/release windows run the counter 0..DEBOUNCE_CYCLES, so the
  // decision lands DEBOUNCE_CYCLES+1 edges after entering the state.
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES);

  logic [2:0]    w_rs;
  keypad_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_col, w_col_nxt;
  logic [2:0]    r_cap_pat, w_cap_pat_nxt;
  logic [3:0]    r_key, w_key_nxt;
  logic [9:0]    r_pb, w_pb_nxt;
  logic          r_key_valid, w_key_valid_nxt;
  logic [3:0]    r_key_idx, w_key_idx_nxt;

  logic          w_one_low;
  logic [1:0]    w_row;
  logic [3:0]    w_k;
  logic          w_hit;

  row_sync #(.WIDTH(3)) u_row_sync (
    .clk  (clk),
    .nrst (nrst),
    .i_d  (row_n),
    .o_q  (w_rs)
  );

  // Exactly one low row identifies a key; two or more low rows are ambiguous.
  always_comb begin
    w_one_low = 1'b1;
    w_row     = 2'd0;
    case (w_rs)
      3'b110:  w_row = 2'd0;
      3'b101:  w_row = 2'd1;
      3'b011:  w_row = 2'd2;
      default: w_one_low = 1'b0;
    endcase
  end

  assign w_k   = key_index(r_col, w_row);
  assign w_hit = w_one_low && (w_k < 4'(NUM_KEYS));

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_col_nxt       = r_col;
    w_cap_pat_nxt   = r_cap_pat;
    w_key_nxt       = r_key;
    w_pb_nxt        = '0;
    w_key_valid_nxt = r_key_valid;
    w_key_idx_nxt   = r_key_idx;
    case (r_state)
      SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_cnt_nxt = '0;
          if (w_hit) begin
            w_state_nxt   = DEBOUNCE;
            w_cap_pat_nxt = w_rs;
            w_key_nxt     = w_k;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (w_rs != r_cap_pat) begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = '0;
          w_col_nxt   = r_col + 2'd1;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt     = HELD;
          w_cnt_nxt       = '0;
          w_pb_nxt        = 10'b1 << r_key;
          w_key_valid_nxt = 1'b1;
          w_key_idx_nxt   = r_key;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      HELD: begin
        // Only the captured row matters; other rows in the frozen column are ignored here.
        if ((w_rs & ~r_cap_pat) != 3'b000) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE: begin
        if (w_rs != 3'b111) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt     = SCAN;
          w_cnt_nxt       = '0;
          w_col_nxt       = r_col + 2'd1;
          w_key_valid_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = SCAN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state     <= SCAN;
      r_cnt       <= '0;
      r_col       <= 2'd0;
      r_cap_pat   <= 3'b111;
      r_key       <= 4'd0;
      r_pb        <= '0;
      r_key_valid <= 1'b0;
      r_key_idx   <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_col       <= w_col_nxt;
      r_cap_pat   <= w_cap_pat_nxt;
      r_key       <= w_key_nxt;
      r_pb        <= w_pb_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_idx   <= w_key_idx_nxt;
    end
  end

  assign col_n     = ~(4'b0001 << r_col);
  assign pb        = r_pb;
  assign key_valid = r_key_valid;
  assign key_idx   = r_key_idx;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model drives row_n from col_n and a set of
// pressed keys; a timestamp-based reference model predicts every output each cycle.
module tb_keypad_scanner;

  localparam int S = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [2:0] row_n;
  logic [3:0] col_n;
  logic [9:0] pb;
  logic       key_valid;
  logic [3:0] key_idx;

  logic [11:0] keys = '0;
  int n_tests = 0;
  int n_fail  = 0;
  int pb_count = 0;
  int wait_cnt;
  int rk, rk2, rhold, ridle;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .row_n     (row_n),
    .col_n     (col_n),
    .pb        (pb),
    .key_valid (key_valid),
    .key_idx   (key_idx)
  );

  // Keypad pads: a pressed key shorts its row to the column currently driven low.
  always_comb begin
    row_n = 3'b111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 3; r++)
        if (col_n[c] === 1'b0 && keys[3*c+r]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_SCAN = 0, M_DEB = 1, M_HOLD = 2, M_REL = 3;
  int         m_mode, m_col, m_t0, m_key, m_idx, m_cap_row, cyc;
  logic [2:0] m_s1, m_s2, m_cap;
  logic [9:0] m_pb;
  logic       m_valid;

  function automatic logic [2:0] pad_rows(input int c);
    logic [2:0] v;
    v = 3'b111;
    for (int r = 0; r < 3; r++) if (keys[3*c+r]) v[r] = 1'b0;
    return v;
  endfunction

  // Advance the model across the coming rising edge using the inputs present now.
  task automatic model_edge();
    logic [2:0] rs;
    int el, nz, row, k;
    cyc++;
    rs   = m_s2;
    m_pb = '0;
    if (nrst) begin
      m_mode = M_SCAN; m_col = 0; m_t0 = cyc; m_valid = 1'b0; m_idx = 0;
      m_s1 = 3'b111; m_s2 = 3'b111;
      return;
    end
    m_s2 = m_s1;
    m_s1 = pad_rows(m_col);
    el = cyc - m_t0;
    case (m_mode)
      M_SCAN: if (el == S) begin
        nz = 0; row = 0;
        for (int r = 0; r < 3; r++) if (!rs[r]) begin nz++; row = r; end
        k = 3*m_col + row;
        if (nz == 1 && k <= 9) begin
          m_mode = M_DEB; m_cap = rs; m_key = k; m_cap_row = row;
        end else begin
          m_col = (m_col + 1) % 4;
        end
        m_t0 = cyc;
      end
      M_DEB: begin
        if (rs != m_cap) begin
          m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_t0 = cyc;
        end else if (el == D + 1) begin
          m_pb[m_key] = 1'b1; m_valid = 1'b1; m_idx = m_key;
          m_mode = M_HOLD; m_t0 = cyc;
        end
      end
      M_HOLD: if (rs[m_cap_row]) begin
        m_mode = M_REL; m_t0 = cyc;
      end
      default: begin
        if (rs != 3'b111) begin
          m_mode = M_HOLD; m_t0 = cyc;
        end else if (el == D + 1) begin
          m_valid = 1'b0; m_col = (m_col + 1) % 4; m_mode = M_SCAN; m_t0 = cyc;
        end
      end
    endcase
  endtask

  task automatic step();
    logic [3:0] exp_col;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    exp_col = 4'b1111;
    exp_col[m_col] = 1'b0;
    check("col_n", 32'(col_n), 32'(exp_col));
    check("pb", 32'(pb), 32'(m_pb));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_idx", 32'(key_idx), 32'(m_idx));
    if (pb !== 10'd0) pb_count++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string tag);
    wait_cnt = 0;
    while (key_valid !== 1'b1 && wait_cnt < 100) begin
      step();
      wait_cnt++;
    end
    check(tag, 32'(key_valid), 32'd1);
  endtask

  initial begin
    // 1: reset and idle scan
    nrst = 1'b1;
    steps(2);
    check("rst_col_n", 32'(col_n), 32'hE);
    nrst = 1'b0;
    pb_count = 0;
    steps(40);
    check("s1_no_pb", pb_count, 0);

    // 2: key 7 held then released
    pb_count = 0;
    keys = '0; keys[7] = 1'b1;
    steps(60);
    check("s2_col_frozen", 32'(col_n), 32'hB);
    check("s2_idx", 32'(key_idx), 32'd7);
    keys = '0;
    steps(40);
    check("s2_pulses", pb_count, 1);
    check("s2_released", 32'(key_valid), 32'd0);

    // 3: key 4 bouncing during debounce, then stable
    pb_count = 0;
    keys = '0; keys[4] = 1'b1;
    wait_cnt = 0;
    while (m_mode != M_DEB && wait_cnt < 100) begin step(); wait_cnt++; end
    for (int t = 0; t < 3; t++) begin
      steps(2);
      keys[4] = ~keys[4];
    end
    keys = '0;
    steps(20);
    check("s3_bounce_no_pb", pb_count, 0);
    keys[4] = 1'b1;
    steps(40);
    check("s3_idx", 32'(key_idx), 32'd4);
    keys = '0;
    steps(30);
    check("s3_pulses", pb_count, 1);

    // 4: ambiguous column, and unmapped key 10
    pb_count = 0;
    keys = '0; keys[3] = 1'b1; keys[5] = 1'b1;
    steps(40);
    keys = '0; keys[10] = 1'b1;
    steps(40);
    keys = '0;
    steps(10);
    check("s4_no_pb", pb_count, 0);

    // 5: glitch while held
    pb_count = 0;
    keys = '0; keys[2] = 1'b1;
    wait_valid("s5_detect");
    keys[2] = 1'b0;
    steps(3);
    keys[2] = 1'b1;
    steps(15);
    check("s5_valid_kept", 32'(key_valid), 32'd1);
    keys = '0;
    steps(30);
    check("s5_pulses", pb_count, 1);

    // 6: reset while held
    keys = '0; keys[5] = 1'b1;
    wait_valid("s6_detect");
    nrst = 1'b1;
    step();
    check("s6_rst_valid", 32'(key_valid), 32'd0);
    check("s6_rst_col", 32'(col_n), 32'hE);
    nrst = 1'b0;
    pb_count = 0;
    steps(60);
    keys = '0;
    steps(30);
    check("s6_pulses", pb_count, 1);

    // Random presses, glitches, multi-key and occasional resets
    for (int it = 0; it < 80; it++) begin
      rk = $urandom_range(0, 11);
      keys = '0;
      keys[rk] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        rk2 = $urandom_range(0, 11);
        keys[rk2] = 1'b1;
      end
      rhold = $urandom_range(1, 50);
      for (int h = 0; h < rhold; h++) begin
        if ($urandom_range(0, 15) == 0) keys[rk] = ~keys[rk];
        nrst = ($urandom_range(0, 199) == 0);
        step();
      end
      nrst = 1'b0;
      keys = '0;
      ridle = $urandom_range(1, 40);
      steps(ridle);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end that produces the calculator's 10-bit pushbutton vector. Scans a 4-column × 3-row keypad, synchronizes and debounces the row sense lines, and emits a one-cycle one-hot strobe on `pb[9:0]` per debounced press. It sits between the board keypad pads and the calculator top, replacing direct pushbutton wiring.

## Interface

**Parameters**
- `SCAN_CYCLES`, default 100: clock cycles each column is driven while idle scanning. Minimum 4.
- `DEBOUNCE_CYCLES`, default 10000: consecutive stable cycles required to accept a press or a release. Minimum 2.

**Ports**
- `clk` input, 1: system clock; all logic on its rising edge.
- `nrst` input, 1: reset, synchronous and active-high (1 = reset).
- `row_n` input, 3: row sense, active-low, asynchronous to `clk` (pads with pull-ups).
- `col_n` output, 4: column drive, active-low; exactly one bit low at all times after reset.
- `pb` output, 10: one-hot strobe, high for exactly one cycle per accepted press.
- `key_valid` output, 1: high from the strobe cycle until the release is accepted.
- `key_idx` output, 4: index of the last accepted key; holds until the next accepted press.

## Operation

- **Key map:** column c (0..3), row r (0..2) gives k = 3c + r. k = 0..9 maps to `pb[k]`. k = 10, 11 are unused and never accepted.
- **Synchronizer:** `row_n` passes through a 2-flop synchronizer. All decisions use the synchronized value `rs`.
- **FSM states:** SCAN, DEBOUNCE, HELD, RELEASE.
- **SCAN**
  - Drive the current column low; the dwell counter counts 0..SCAN_CYCLES-1.
  - On the last dwell cycle, sample `rs`.
  - If exactly one row is low and k ≤ 9: capture the row and k, then go to DEBOUNCE with the column frozen.
  - Otherwise advance the column (3 wraps to 0) and restart the dwell.
- **DEBOUNCE**
  - Count DEBOUNCE_CYCLES cycles; every cycle `rs` must equal the captured pattern.
  - Any mismatch: return to SCAN, advance the column, no strobe.
  - On completion: strobe `pb[k]`, load `key_idx` = k, set `key_valid`, go to HELD.
- **HELD**
  - Column stays frozen.
  - Stay while the captured row is low.
  - When the captured row reads high, go to RELEASE with the counter cleared.
- **RELEASE**
  - Requires DEBOUNCE_CYCLES consecutive cycles with all rows high.
  - Any low row: return to HELD, no new strobe, `key_valid` stays 1.
  - On completion: clear `key_valid`, advance the column, go to SCAN.
- **Boundary rules**
  - Multiple rows low in one column count as no key.
  - Keys pressed in other columns while HELD are ignored.
  - Only one key is tracked at a time.
- **Counters:** width `$clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)+1)`, unsigned. They saturate never, because every state clears its counter on exit.

## Timing

- **Reset values** (one cycle after `nrst` is sampled high):
  - state SCAN, column 0, `col_n` = 4'b1110
  - `pb` = 0, `key_valid` = 0, `key_idx` = 0
  - synchronizer flops = 3'b111, counters = 0
- **Reset mid-operation:** any state returns to these values. A strobe is never emitted in the reset cycle.
- **Synchronizer latency:** 2 cycles. Because SCAN_CYCLES ≥ 4, the sample sees the current column's rows settled.
- **Idle scan period:** 4·SCAN_CYCLES cycles. `col_n` changes on the edge after the last dwell cycle.
- **Press latency:** `pb` is high in the cycle exactly DEBOUNCE_CYCLES+1 edges after the SCAN sample edge. It is registered, so it is never combinational from `row_n`.
- **Release:** `key_valid` falls DEBOUNCE_CYCLES+1 edges after the first all-high `rs` cycle in HELD. `col_n` advances on the same edge.
- **Back-to-back presses:** each press produces one strobe. There is no minimum gap beyond the release debounce.

## Structure

- **Package `keypad_pkg`:**
  - state enum `keypad_state_t` {SCAN, DEBOUNCE, HELD, RELEASE}
  - constants NUM_COLS = 4, NUM_ROWS = 3, NUM_KEYS = 10
  - function `key_index(col, row)` returning 3·col + row
- **Sub-module `row_sync`:** a parameterized-width 2-flop synchronizer with a reset value of all-ones. It is instantiated once, at width 3.
- **Top:** the FSM, dwell/debounce counter, column register and output registers.

## Test plan

All scenarios use SCAN_CYCLES=4 and DEBOUNCE_CYCLES=8.

1. Reset, rows idle (3'b111) for 40 cycles: `col_n` cycles 1110, 1101, 1011, 0111, 1110, 4 cycles each. `pb` = 0 and `key_valid` = 0 throughout.
2. Hold key 7 (row 1 low while `col_n`=1011) for 60 cycles, then release:
   - exactly one `pb` = 10'b0010000000 pulse, 9 edges after the sample
   - `key_idx` = 7, `col_n` frozen at 1011 while held
   - `key_valid` falls 9 edges after release, then scanning resumes at 0111
3. Key 4 pressed but toggling every 2 cycles during DEBOUNCE: no strobe, return to SCAN at the next column. The same key then held stable gives one strobe with `pb[4]`.
4. Rows 0 and 2 both low in column 1: no strobe, and the scan continues. Key 10 (column 3, row 1) held: no strobe ever.
5. In HELD with key 2, glitch the row high for 3 cycles: returns to HELD, no second strobe, `key_valid` stays 1.
6. Assert `nrst` for one cycle while in HELD: the next cycle shows all reset values. The still-held key is re-detected and strobes once after a full scan plus debounce.
